me_load_scheduler: RTL and testbench
====================================

ME_LOAD_SCHEDULER -- requirements
Module: me_load_scheduler

Interface
REQ-001 Parameter: BEATS_CUR, 32, 64-bit beats per current-block fill (2048 bits).
REQ-002 Parameter: BEATS_SRC, 32, 64-bit beats per search-window fill.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: cur_req  input  1  controller requests a current-block fill; level, sampled each cycle.
REQ-006 Port: src_req  input  1  address generator requests a search-window fill (search_WE_req); level.
REQ-007 Port: in_valid  input  1  upstream beat valid.
REQ-008 Port: in_ready  output  1  scheduler accepts a beat this cycle.
REQ-009 Port: in_sel  output  1  stream selector to upstream: 0 = current block, 1 = search window.
REQ-010 Port: cur_WE  output  1  write enable to current-block register file.
REQ-011 Port: search_WE  output  1  write enable to search register file.
REQ-012 Port: curfilled  output  1  current block completely loaded.
REQ-013 Port: srcfilled  output  1  search window completely loaded.
REQ-014 Port: busy  output  1  a burst is in progress.
REQ-015 Port: err  output  1  one-cycle pulse on burst abort (REQ-031 only); tied 0 otherwise.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_CUR, LOAD_SRC.
REQ-017 In IDLE, with exactly one request high and its filled flag low, next state SHALL be the matching LOAD state.
REQ-018 When both requests are eligible in IDLE, grant SHALL go round-robin: the stream not granted most recently wins; after reset, current block wins first.
REQ-019 A burst SHALL never be preempted; the other request waits until return to IDLE.
REQ-020 in_ready SHALL be 1 only in LOAD_CUR/LOAD_SRC; a beat transfers when in_valid & in_ready.
REQ-021 cur_WE = transfer & LOAD_CUR; search_WE = transfer & LOAD_SRC; combinational, zero latency.
REQ-022 in_sel SHALL be 1 in LOAD_SRC, 0 otherwise, registered with the state.
REQ-023 A 6-bit beat counter SHALL clear on burst entry and increment per transfer; in_valid low stalls it with no write.
REQ-024 On the final transfer (count = BEATS-1), next state SHALL be IDLE and the corresponding filled flag SHALL set on the following cycle.
REQ-025 A filled flag SHALL clear when its request drops; a request with its flag already set SHALL not be granted.
REQ-026 Both requests must see one IDLE cycle between bursts; back-to-back grants SHALL not skip IDLE.
REQ-027 Request deassertion mid-burst SHALL be ignored; the burst completes.
REQ-028 busy SHALL equal (state != IDLE).

Reset
REQ-029 With reset low at a rising clk edge: state IDLE, counter 0, round-robin pointer to current block, curfilled 0, srcfilled 0, err 0; in_ready, cur_WE, search_WE, in_sel, busy SHALL be 0 in the following cycle.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no further WE pulses; no filled flag set.

Configuration
REQ-031 With ME_LOAD_TIMEOUT_EN defined, an 8-bit idle counter SHALL count in-burst cycles without transfer; at 255 the FSM SHALL return to IDLE, pulse err one cycle, and leave the filled flag clear; without the macro no counter exists and err is constant 0.

Structure
REQ-032 Package me_load_pkg SHALL hold the state enum, BEATS_CUR/BEATS_SRC defaults, and timeout limit constant.
REQ-033 Two-requester round-robin SHALL live in sub-module me_rr_arb2 (inputs req[1:0], update strobe; output grant[1:0]).

Verification
REQ-034 cur_req high, in_valid constant 1 -> 32 cur_WE pulses in consecutive cycles, curfilled 1 from cycle 34, search_WE never 1.
REQ-035 cur_req and src_req rise together after reset -> current burst first (32 beats), one IDLE cycle, then 32 search_WE with in_sel 1.
REQ-036 in_valid toggling 1/0 during LOAD_SRC -> exactly 32 search_WE pulses over 63 cycles, srcfilled sets after the 32nd.
REQ-037 reset low at beat 10 of LOAD_CUR -> next cycle in_ready 0, curfilled 0; after release and cur_req, a full 32-beat burst restarts.
REQ-038 ME_LOAD_TIMEOUT_EN defined, in_valid held 0 after 5 beats -> err pulses after 255 stalled cycles, state IDLE, srcfilled 0.
REQ-039 src_req drops at beat 20 -> burst still completes 32 beats; srcfilled sets then clears next cycle.

Source files
------------

// File: rtl/me_load_pkg.sv
// Shared types and constants for the motion-estimation load scheduler.
// TIMEOUT_LIMIT is only used when ME_LOAD_TIMEOUT_EN is defined.
package me_load_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_CUR = 2'd1,
    LOAD_SRC = 2'd2
  } state_e;

  localparam int BEATS_CUR_DEF = 32;
  localparam int BEATS_SRC_DEF = 32;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/me_load_scheduler_if.sv
// Upstream beat stream: valid from the source, ready/select from the scheduler.
// The master modport is the beat source, the slave modport is the scheduler.
interface me_load_scheduler_if;

  logic in_valid;
  logic in_ready;
  logic in_sel;

  modport master (
    output in_valid,
    input  in_ready,
    input  in_sel
  );

  modport slave (
    input  in_valid,
    output in_ready,
    output in_sel
  );

endinterface

// File: rtl/me_rr_arb2.sv
// Two-requester round-robin arbiter; req[0] is the current block.
// On a tie, the requester not granted most recently wins.
module me_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio_src_q;
  logic prio_src_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio_src_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_src_d = prio_src_q;
    if (update) begin
      unique case (1'b1)
        grant[0]: prio_src_d = 1'b1;
        grant[1]: prio_src_d = 1'b0;
        default:  prio_src_d = prio_src_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_src_q <= 1'b0;
    end else begin
      prio_src_q <= prio_src_d;
    end
  end

endmodule

// File: rtl/me_load_scheduler.sv
// Schedules 64-bit beat bursts into the current-block or search-window file.
// Optional burst-stall abort is enabled with `define ME_LOAD_TIMEOUT_EN.
module me_load_scheduler
  import me_load_pkg::*;
#(
  parameter int BEATS_CUR = BEATS_CUR_DEF,
  parameter int BEATS_SRC = BEATS_SRC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cur_req,
  input  logic                 src_req,
  me_load_scheduler_if.slave   up,
  output logic                 cur_WE,
  output logic                 search_WE,
  output logic                 curfilled,
  output logic                 srcfilled,
  output logic                 busy,
  output logic                 err
);

  state_e     state_q;
  state_e     state_d;
  logic [5:0] cnt_q;
  logic [5:0] cnt_d;
  logic       in_sel_q;
  logic       in_sel_d;
  logic       curf_q;
  logic       curf_d;
  logic       srcf_q;
  logic       srcf_d;

  logic [1:0] arb_req;
  logic [1:0] grant;
  logic       xfer;
  logic [5:0] last_cnt;
  logic       last_beat;
  logic       tmo;

  assign up.in_ready = (state_q != IDLE);
  assign up.in_sel   = in_sel_q;

  assign xfer      = up.in_valid & up.in_ready;
  assign last_cnt  = (state_q == LOAD_SRC) ? 6'(BEATS_SRC - 1)
                                           : 6'(BEATS_CUR - 1);
  assign last_beat = xfer & (cnt_q == last_cnt);

  assign cur_WE    = xfer & (state_q == LOAD_CUR);
  assign search_WE = xfer & (state_q == LOAD_SRC);
  assign curfilled = curf_q;
  assign srcfilled = srcf_q;
  assign busy      = (state_q != IDLE);

  // A stream already holding a filled window is not eligible again.
  assign arb_req = {src_req & ~srcf_q, cur_req & ~curf_q};

  me_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .update (state_q == IDLE),
    .grant  (grant)
  );

`ifdef ME_LOAD_TIMEOUT_EN
  logic [7:0] idle_q;
  logic [7:0] idle_d;
  logic       err_q;

  assign tmo = busy & ~xfer
             & (idle_q == TIMEOUT_LIMIT - 8'd1);

  always_comb begin
    idle_d = idle_q + 8'd1;
    if (!busy || xfer || tmo) begin
      idle_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= tmo;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 6'd0;
        if (grant[0]) begin
          state_d = LOAD_CUR;
        end else if (grant[1]) begin
          state_d = LOAD_SRC;
        end
      end
      LOAD_CUR, LOAD_SRC: begin
        if (xfer) begin
          cnt_d = cnt_q + 6'd1;
        end
        if (last_beat || tmo) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion wins over a same-cycle request drop; the drop clears next.
  always_comb begin
    in_sel_d = (state_d == LOAD_SRC);
    curf_d   = (curf_q & cur_req)
             | (last_beat & (state_q == LOAD_CUR));
    srcf_d   = (srcf_q & src_req)
             | (last_beat & (state_q == LOAD_SRC));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      in_sel_q <= 1'b0;
      curf_q   <= 1'b0;
      srcf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_sel_q <= in_sel_d;
      curf_q   <= curf_d;
      srcf_q   <= srcf_d;
    end
  end

endmodule

// File: tb/tb_me_load_scheduler.sv
// Self-checking bench for me_load_scheduler: directed scenarios plus a
// randomized run against a burst-level reference model.
module tb_me_load_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cur_req = 1'b0;
  logic src_req = 1'b0;
  logic cur_WE;
  logic search_WE;
  logic curfilled;
  logic srcfilled;
  logic busy;
  logic err;

  int checks = 0;
  int errors = 0;

  me_load_scheduler_if bus ();

  me_load_scheduler #(
    .BEATS_CUR (32),
    .BEATS_SRC (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cur_req   (cur_req),
    .src_req   (src_req),
    .up        (bus),
    .cur_WE    (cur_WE),
    .search_WE (search_WE),
    .curfilled (curfilled),
    .srcfilled (srcfilled),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {bus.in_ready, cur_WE, search_WE, bus.in_sel,
            busy, curfilled, srcfilled, err};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cur_req = 1'b0;
    src_req = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] o;
    @(negedge clk);
    reset = 1'b0;
    cur_req = 1'b1;
    src_req = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      o = outs();
      checks++;
      if (o !== 8'h00) begin
        errors++;
        $display("FAIL reset_outs cyc%0d: got %b want 00000000", i, o);
      end
    end
    do_reset();
  endtask

  task automatic test_cur_fill();
    int n = 0, first = -1, last = -1, fill = -1, sw = 0, sel = 0;
    do_reset();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      cur_req = 1'b1;
      bus.in_valid = 1'b1;
      #1;
      if (cur_WE) begin
        n++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (search_WE) sw++;
      if (bus.in_sel) sel++;
      if (curfilled && fill < 0) fill = cyc;
      @(negedge clk);
    end
    checks++;
    if (n !== 32) begin errors++; $display("FAIL cur_count: got %0d want 32", n); end
    checks++;
    if (first !== 2) begin errors++; $display("FAIL cur_first: got %0d want 2", first); end
    checks++;
    if (last !== 33) begin errors++; $display("FAIL cur_last: got %0d want 33", last); end
    checks++;
    if (fill !== 34) begin errors++; $display("FAIL curfilled_cyc: got %0d want 34", fill); end
    checks++;
    if (sw !== 0 || sel !== 0) begin
      errors++;
      $display("FAIL cur_no_src: search_WE %0d in_sel %0d want 0 0", sw, sel);
    end
  endtask

  task automatic test_both();
    int cn = 0, cf = -1, cl = -1, sn = 0, sf = -1, sl = -1, bad = 0;
    logic b34 = 1'bx;
    do_reset();
    for (int cyc = 1; cyc <= 75; cyc++) begin
      cur_req = 1'b1;
      src_req = 1'b1;
      bus.in_valid = 1'b1;
      #1;
      if (cur_WE) begin
        cn++;
        if (cf < 0) cf = cyc;
        cl = cyc;
        if (bus.in_sel) bad++;
      end
      if (search_WE) begin
        sn++;
        if (sf < 0) sf = cyc;
        sl = cyc;
        if (!bus.in_sel) bad++;
      end
      if (cyc == 34) b34 = busy;
      @(negedge clk);
    end
    checks++;
    if (cn !== 32 || cf !== 2 || cl !== 33) begin
      errors++;
      $display("FAIL both_cur: got n%0d %0d..%0d want n32 2..33", cn, cf, cl);
    end
    checks++;
    if (b34 !== 1'b0) begin errors++; $display("FAIL both_idle_gap: busy %b want 0", b34); end
    checks++;
    if (sn !== 32 || sf !== 35 || sl !== 66) begin
      errors++;
      $display("FAIL both_src: got n%0d %0d..%0d want n32 35..66", sn, sf, sl);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL both_in_sel: got %0d bad want 0", bad); end
  endtask

  task automatic test_toggle();
    int n = 0, first = -1, last = -1, fill = -1, cw = 0;
    do_reset();
    for (int cyc = 1; cyc <= 70; cyc++) begin
      src_req = 1'b1;
      bus.in_valid = (cyc % 2 == 0);
      #1;
      if (search_WE) begin
        n++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (cur_WE) cw++;
      if (srcfilled && fill < 0) fill = cyc;
      @(negedge clk);
    end
    checks++;
    if (n !== 32 || cw !== 0) begin
      errors++;
      $display("FAIL toggle_count: got src %0d cur %0d want 32 0", n, cw);
    end
    checks++;
    if (last - first + 1 !== 63) begin
      errors++;
      $display("FAIL toggle_span: got %0d want 63", last - first + 1);
    end
    checks++;
    if (fill !== last + 1) begin
      errors++;
      $display("FAIL toggle_fill: got %0d want %0d", fill, last + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, n2 = 0;
    bit found = 0;
    do_reset();
    cur_req = 1'b1;
    bus.in_valid = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      #1;
      if (cur_WE) n++;
      if (n == 10) begin
        reset = 1'b0;
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmid_reach10: got %0d beats want 10", n); end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.in_ready, cur_WE, curfilled} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_after: got %b want 000", {bus.in_ready, cur_WE, curfilled});
    end
    reset = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #1;
      if (cur_WE) n2++;
      @(negedge clk);
    end
    checks++;
    if (n2 !== 32 || curfilled !== 1'b1) begin
      errors++;
      $display("FAIL rmid_restart: got %0d beats filled %b want 32 1", n2, curfilled);
    end
  endtask

  task automatic test_drop();
    int n = 0, last = -1;
    logic f34 = 1'bx, f35 = 1'bx;
    do_reset();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      src_req = (n < 20);
      bus.in_valid = 1'b1;
      #1;
      if (search_WE) begin
        n++;
        last = cyc;
      end
      if (cyc == 34) f34 = srcfilled;
      if (cyc == 35) f35 = srcfilled;
      @(negedge clk);
    end
    checks++;
    if (n !== 32 || last !== 33) begin
      errors++;
      $display("FAIL drop_count: got %0d last %0d want 32 33", n, last);
    end
    checks++;
    if (f34 !== 1'b1 || f35 !== 1'b0) begin
      errors++;
      $display("FAIL drop_fill: got %b%b want 10", f34, f35);
    end
  endtask

`ifdef ME_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0, ecyc = -1;
    logic eb = 1'bx, ef = 1'bx, enext = 1'bx;
    do_reset();
    for (int cyc = 1; cyc <= 400; cyc++) begin
      src_req = 1'b1;
      bus.in_valid = (n < 5);
      #1;
      if (search_WE) n++;
      if (err) begin
        ecyc = cyc;
        eb = busy;
        ef = srcfilled;
        @(negedge clk);
        #1;
        enext = err;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (ecyc !== 262) begin errors++; $display("FAIL tmo_cycle: got %0d want 262", ecyc); end
    checks++;
    if ({eb, ef, enext} !== 3'b000) begin
      errors++;
      $display("FAIL tmo_state: busy/filled/err_next %b want 000", {eb, ef, enext});
    end
  endtask
`endif

  task automatic test_random();
    int mb = 0, left = 0, lastg = 2, bursts = 0, pick;
    logic mcf = 0, msf = 0, ncf, nsf, v;
    logic [7:0] exp_o, o;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 39) == 0) cur_req = ~cur_req;
      if ($urandom_range(0, 39) == 0) src_req = ~src_req;
      v = ($urandom_range(0, 9) < 7);
      bus.in_valid = v;
      exp_o = {mb != 0, mb == 1 && v, mb == 2 && v, mb == 2,
               mb != 0, mcf, msf, 1'b0};
      #1;
      o = outs();
      checks++;
      if (o !== exp_o) begin
        errors++;
        $display("FAIL rand_cyc%0d: got %b want %b", cyc, o, exp_o);
      end
      ncf = mcf & cur_req;
      nsf = msf & src_req;
      if (mb != 0) begin
        if (v) left--;
        if (left == 0) begin
          if (mb == 1) ncf = 1'b1;
          else nsf = 1'b1;
          mb = 0;
          bursts++;
        end
      end else begin
        pick = 0;
        if (cur_req && !mcf && src_req && !msf) pick = (lastg == 1) ? 2 : 1;
        else if (cur_req && !mcf) pick = 1;
        else if (src_req && !msf) pick = 2;
        if (pick != 0) begin
          mb = pick;
          left = 32;
          lastg = pick;
        end
      end
      mcf = ncf;
      msf = nsf;
      @(negedge clk);
    end
    checks++;
    if (bursts < 5) begin errors++; $display("FAIL rand_bursts: got %0d want >=5", bursts); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    test_reset();
    test_cur_fill();
    test_both();
    test_toggle();
    test_reset_mid();
    test_drop();
`ifdef ME_LOAD_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
